uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// FIFO-fed UART transmitter: 7/8 data bits, optional odd/even parity, oversampled bit timing.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_serializer #(
  parameter int RD_LATENCY = 2,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       baud_en,
  input  logic       fifo_empty,
  output logic       fifo_read_n,
  input  logic [7:0] fifo_data,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  localparam int TW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int LAT = (RD_LATENCY > 0) ? RD_LATENCY : 1;
  localparam int LW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(LAT - 1);
`ifdef UART_TX_TWO_STOP_EN
  localparam logic [2:0] STOP_LAST = 3'd1;
`else
  localparam logic [2:0] STOP_LAST = 3'd0;
`endif

  // Parity over the already-masked data byte; odd selects inversion.
  function automatic logic frame_parity(input logic [7:0] data, input logic odd);
    frame_parity = (^data) ^ odd;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic          bit8_q, bit8_d;
  logic          par_en_q, par_en_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          read_req;
  logic          bit_end;
  logic [7:0]    load_byte;
  logic [2:0]    data_last;

  // The read strobe is decoded from the registered state so it lands in the IDLE exit cycle itself.
  assign read_req    = (state_q == S_IDLE) && !fifo_empty && !reset;
  assign fifo_read_n = !read_req;
  assign tx          = tx_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    lat_d     = lat_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    bit8_d    = bit8_q;
    par_en_d  = par_en_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    load_byte = bit8 ? fifo_data : {1'b0, fifo_data[6:0]};
    data_last = bit8_q ? 3'd7 : 3'd6;
    bit_end   = baud_en && (tick_q == TICK_LAST);

    // Tick counter only runs while a bit is on the line.
    if ((state_q == S_START) || (state_q == S_DATA) ||
        (state_q == S_PARITY) || (state_q == S_STOP)) begin
      if (baud_en) begin
        tick_d = bit_end ? '0 : tick_q + 1'b1;
      end else begin
        tick_d = tick_q;
      end
    end else begin
      tick_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        lat_d = '0;
        if (read_req) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        tx_d = 1'b1;
        if (lat_q == LAT_LAST) begin
          state_d   = S_START;
          shreg_d   = load_byte;
          parity_d  = frame_parity(load_byte, odd_n_even);
          bit8_d    = bit8;
          par_en_d  = parity_en;
          bit_cnt_d = 3'd0;
          lat_d     = '0;
          tx_d      = 1'b0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
          tx_d      = shreg_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == data_last) begin
            bit_cnt_d = 3'd0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end else begin
          tx_d = shreg_q[0];
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = 3'd0;
          tx_d      = 1'b1;
        end else begin
          tx_d = parity_q;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset that aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      lat_q     <= '0;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'd0;
      parity_q  <= 1'b0;
      bit8_q    <= 1'b0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      lat_q     <= lat_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      parity_q  <= parity_d;
      bit8_q    <= bit8_d;
      par_en_q  <= par_en_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: table vectors, corner sequences, random frames vs model.
module tb_uart_tx_serializer;

  localparam int RD_LAT = 2;
  localparam int OS     = 16;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  logic       clock;
  logic       reset;
  logic       baud_en;
  logic       fifo_empty;
  logic       fifo_read_n;
  logic [7:0] fifo_data;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_serializer #(.RD_LATENCY(RD_LAT), .OVERSAMPLE(OS)) dut (
    .clock(clock), .reset(reset), .baud_en(baud_en), .fifo_empty(fifo_empty),
    .fifo_read_n(fifo_read_n), .fifo_data(fifo_data), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .tx(tx),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         compared = 0;
  int         failed   = 0;
  int         strobes  = 0;
  int         bad_reads = 0;
  bit         baud_rand = 1'b0;
  logic [7:0] q[$];
  logic [7:0] pipe[RD_LAT];
  logic       exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic        b8;
    logic        pe;
    logic        odd;
    logic [11:0] bits;   // frame bits, bit 0 sent first (one stop bit)
    int          len;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // One clock: FIFO model reacts to the strobe seen before the edge, then new inputs settle.
  task automatic cycle();
    logic        rd_n;
    logic [31:0] r;
    #1;
    rd_n = fifo_read_n;
    if (rd_n === 1'b0) begin
      strobes++;
      if (fifo_empty || reset) bad_reads++;
    end
    @(posedge clock);
    #1;
    for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    r = $urandom;
    if (rd_n === 1'b0 && q.size() > 0) pipe[0] = q.pop_front();
    else pipe[0] = r[7:0];
    fifo_data  = pipe[RD_LAT-1];
    fifo_empty = (q.size() == 0);
    baud_en    = baud_rand ? (r[9:8] == 2'b00) : 1'b1;
    #2;
  endtask

  // Expected line levels for one frame, one entry per bit period.
  task automatic model_frame(input logic [7:0] data, input logic b8, input logic pe, input logic odd);
    int   nb;
    int   ones;
    logic par;
    exp_q.delete();
    exp_q.push_back(1'b0);
    nb   = b8 ? 8 : 7;
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(data[i]);
      if (data[i]) ones++;
    end
    par = ((ones % 2) != 0);
    if (pe) exp_q.push_back(par ^ odd);
    for (int i = 0; i < STOP_BITS; i++) exp_q.push_back(1'b1);
  endtask

  task automatic check_frame(input string name, input bit scramble);
    int          guard;
    int          pulses;
    int          total;
    int          bad;
    int          first_bad;
    logic        bad_act;
    int          busy_bad;
    int          done_bad;
    logic [31:0] r;
    guard = 0;
    while (tx !== 1'b0 && guard < 400) begin
      cycle();
      guard++;
    end
    compared++;
    if (tx !== 1'b0) begin
      failed++;
      $display("FAIL %s start_timeout: tx=%b required 0 within 400 cycles", name, tx);
      return;
    end
    total = exp_q.size() * OS;
    pulses = 0; bad = 0; first_bad = -1; bad_act = 1'b0; busy_bad = 0; done_bad = 0; guard = 0;
    while (pulses < total && guard < total * 20) begin
      if (tx !== exp_q[pulses / OS]) begin
        if (bad == 0) begin
          first_bad = pulses / OS;
          bad_act   = tx;
        end
        bad++;
      end
      if (tx_busy !== 1'b1) busy_bad++;
      if (tx_done !== 1'b0) done_bad++;
      if (scramble) begin
        r = $urandom;
        bit8 = r[0]; parity_en = r[1]; odd_n_even = r[2];
      end
      if (baud_en) pulses++;
      cycle();
      guard++;
    end
    check({name, "_pulses"}, 32'(pulses), 32'(total));
    compared++;
    if (bad != 0) begin
      failed++;
      $display("FAIL %s frame_bits: bit %0d tx=%b required %b (%0d bad cycles)",
               name, first_bad, bad_act, exp_q[first_bad], bad);
    end
    check({name, "_busy_bad_cycles"}, 32'(busy_bad), 32'd0);
    check({name, "_early_done"}, 32'(done_bad), 32'd0);
    check({name, "_done_pulse"}, 32'(tx_done), 32'd1);
    check({name, "_idle_tx"}, 32'(tx), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          errs;
    int          n;
    logic [31:0] r;
    logic [7:0]  bb[3];
    logic        c8[3];
    logic        cp[3];
    logic        co[3];

    tbl[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 12'h2AA, 10};
    tbl[1] = '{8'hC3, 1'b0, 1'b1, 1'b0, 12'h386, 10};
    tbl[2] = '{8'hFF, 1'b1, 1'b0, 1'b0, 12'h3FE, 10};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 12'h600, 11};
    tbl[4] = '{8'h80, 1'b0, 1'b1, 1'b0, 12'h200, 10};
    tbl[5] = '{8'hA5, 1'b1, 1'b1, 1'b0, 12'h54A, 11};
    tbl[6] = '{8'h7E, 1'b0, 1'b0, 1'b0, 12'h1FC, 9};
    tbl[7] = '{8'h01, 1'b1, 1'b1, 1'b1, 12'h402, 11};

    reset = 1'b1; baud_en = 1'b1; fifo_empty = 1'b1; fifo_data = 8'h00;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    for (int i = 0; i < RD_LAT; i++) pipe[i] = 8'h00;
    for (int i = 0; i < 3; i++) cycle();
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_read_n", 32'(fifo_read_n), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);

    // Empty FIFO: line must stay quiet.
    reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (tx !== 1'b1 || fifo_read_n !== 1'b1 || tx_busy !== 1'b0) errs++;
    end
    check("idle_100_bad_cycles", 32'(errs), 32'd0);

    // Table vectors, baud_en every cycle.
    for (int i = 0; i < 8; i++) begin
      bit8 = tbl[i].b8; parity_en = tbl[i].pe; odd_n_even = tbl[i].odd;
      exp_q.delete();
      for (int j = 0; j < tbl[i].len; j++) exp_q.push_back(tbl[i].bits[j]);
      for (int j = 1; j < STOP_BITS; j++) exp_q.push_back(1'b1);
      base = strobes;
      q.push_back(tbl[i].data);
      check_frame($sformatf("vec%0d", i), 1'b0);
      check($sformatf("vec%0d_strobes", i), 32'(strobes - base), 32'd1);
      for (int k = 0; k < 3; k++) cycle();
    end

    // Three queued bytes go out back to back.
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    base = strobes;
    q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03);
    for (int k = 0; k < 3; k++) begin
      model_frame(8'(k + 1), 1'b1, 1'b0, 1'b0);
      check_frame($sformatf("b2b%0d", k), 1'b0);
      if (k < 2) check($sformatf("b2b%0d_read_in_done_cycle", k), 32'(fifo_read_n), 32'd0);
    end
    check("b2b_strobes", 32'(strobes - base), 32'd3);
    for (int k = 0; k < 3; k++) cycle();

    // Reset in the middle of a frame, then a clean frame.
    base = strobes;
    q.push_back(8'hA5);
    n = 0;
    while (tx !== 1'b0 && n < 400) begin cycle(); n++; end
    for (int k = 0; k < 3 * OS; k++) cycle();
    q.push_back(8'h7E);
    reset = 1'b1;
    cycle();
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_done", 32'(tx_done), 32'd0);
    for (int k = 0; k < 3; k++) cycle();
    check("abort_no_read_in_reset", 32'(strobes - base), 32'd1);
    reset = 1'b0;
    model_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    check_frame("after_reset", 1'b0);
    check("after_reset_strobes", 32'(strobes - base), 32'd2);
    for (int k = 0; k < 3; k++) cycle();

    // Random frames, sparse baud ticks, config scrambled mid-frame.
    baud_rand = 1'b1;
    for (int b = 0; b < 10; b++) begin
      r = $urandom;
      n = 1 + int'(r[1:0] % 3);
      for (int k = 0; k < n; k++) begin
        r = $urandom;
        bb[k] = r[7:0]; c8[k] = r[8]; cp[k] = r[9]; co[k] = r[10];
      end
      bit8 = c8[0]; parity_en = cp[0]; odd_n_even = co[0];
      base = strobes;
      for (int k = 0; k < n; k++) q.push_back(bb[k]);
      for (int k = 0; k < n; k++) begin
        bit8 = c8[k]; parity_en = cp[k]; odd_n_even = co[k];
        model_frame(bb[k], c8[k], cp[k], co[k]);
        check_frame($sformatf("rnd%0d_%0d", b, k), 1'b1);
      end
      check($sformatf("rnd%0d_strobes", b), 32'(strobes - base), 32'(n));
      r = $urandom;
      for (int k = 0; k < 2 + int'(r[1:0]); k++) cycle();
    end

    check("read_while_empty_or_reset", 32'(bad_reads), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
